// File: rtl/param_regfile_pkg.sv
// Shared constants and types for the parameter register file controller.
package param_regfile_pkg;

  localparam logic [3:0] OP_LD = 4'd0;
  localparam logic [3:0] OP_ST = 4'd1;
  localparam logic [3:0] OP_MI = 4'd2;
  localparam logic [3:0] OP_MR = 4'd3;

  localparam int FLAG_CY = 1;
  localparam int FLAG_Z  = 0;

  localparam logic [1:0] DBG_RD = 2'b10;
  localparam logic [1:0] DBG_WR = 2'b01;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_MEM  = 1'b1
  } state_e;

endpackage

// File: rtl/regfile_array.sv
// Register storage: one instruction write port, one debug write port, two async read ports.
module regfile_array #(
  parameter int DW = 8,
  parameter int NREG = 4,
  localparam int RW = $clog2(NREG)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          iw_en,
  input  logic [RW-1:0] iw_addr,
  input  logic [DW-1:0] iw_data,
  input  logic          dw_en,
  input  logic [RW-1:0] dw_addr,
  input  logic [DW-1:0] dw_data,
  input  logic [RW-1:0] rs_addr,
  output logic [DW-1:0] rs_data,
  input  logic [RW-1:0] dbg_addr,
  output logic [DW-1:0] dbg_data
);

  logic [DW-1:0] regs_q [NREG];
  logic [DW-1:0] regs_d [NREG];

  // Instruction write is applied last so it overrides a debug write to the same register.
  always_comb begin
    regs_d = regs_q;
    if (dw_en) regs_d[dw_addr] = dw_data;
    if (iw_en) regs_d[iw_addr] = iw_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
    end else begin
      regs_q <= regs_d;
    end
  end

  assign rs_data  = regs_q[rs_addr];
  assign dbg_data = regs_q[dbg_addr];

endmodule

// File: rtl/param_regfile.sv
// Instruction-driven parameter register file with a single-outstanding memory port
// and an always-available debug read/write port.
module param_regfile
  import param_regfile_pkg::*;
#(
  parameter int DW = 8,
  parameter int NREG = 4,
  parameter int AW = 4,
  parameter int IMMW = 2,
  localparam int RW = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      op,
  input  logic [RW-1:0]   rd,
  input  logic [RW-1:0]   rs,
  input  logic [IMMW-1:0] imm,
  input  logic [AW-1:0]   addr,
  input  logic [1:0]      flags_in,
  output logic [1:0]      flags,
  output logic            illegal,
  output logic            mem_req,
  output logic            mem_we,
  output logic [AW-1:0]   mem_addr,
  output logic [DW-1:0]   mem_wdata,
  input  logic            mem_ack,
  input  logic [DW-1:0]   mem_rdata,
  input  logic [1:0]      dbg_rw,
  input  logic [RW-1:0]   dbg_reg,
  input  logic [DW-1:0]   dbg_wdata,
  output logic [DW-1:0]   dbg_rdata,
  output logic            dbg_rvalid
);

  state_e        state_q, state_d;
  logic [1:0]    flags_q, flags_d;
  logic          illegal_q, illegal_d;
  logic          mem_req_q, mem_req_d;
  logic          mem_we_q, mem_we_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;
  logic [RW-1:0] req_rd_q, req_rd_d;
  logic [DW-1:0] dbg_rdata_q, dbg_rdata_d;
  logic          dbg_rvalid_q, dbg_rvalid_d;

  logic          accept;
  logic          iw_en;
  logic [RW-1:0] iw_addr;
  logic [DW-1:0] iw_data;
  logic [DW-1:0] rs_data;
  logic [DW-1:0] dbg_data;
  logic [DW-1:0] imm_ext;

  assign imm_ext = DW'($signed(imm));
  assign accept  = in_valid & in_ready;

  regfile_array #(
    .DW   (DW),
    .NREG (NREG)
  ) u_array (
    .clk      (clk),
    .rst      (rst),
    .iw_en    (iw_en),
    .iw_addr  (iw_addr),
    .iw_data  (iw_data),
    .dw_en    (dbg_rw == DBG_WR),
    .dw_addr  (dbg_reg),
    .dw_data  (dbg_wdata),
    .rs_addr  (rs),
    .rs_data  (rs_data),
    .dbg_addr (dbg_reg),
    .dbg_data (dbg_data)
  );

  always_comb begin
    state_d     = state_q;
    flags_d     = flags_q;
    illegal_d   = 1'b0;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    req_rd_d    = req_rd_q;
    iw_en       = 1'b0;
    iw_addr     = rd;
    iw_data     = imm_ext;
    in_ready    = (state_q == S_IDLE);

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          flags_d = flags_in;
          case (op)
            OP_LD, OP_ST: begin
              state_d     = S_MEM;
              mem_req_d   = 1'b1;
              mem_we_d    = (op == OP_ST);
              mem_addr_d  = addr;
              mem_wdata_d = rs_data;
              req_rd_d    = rd;
            end
            OP_MI: iw_en = 1'b1;
            OP_MR: begin
              iw_en   = 1'b1;
              iw_data = rs_data;
            end
            default: illegal_d = 1'b1;
          endcase
        end
      end
      S_MEM: begin
        // mem_we_q doubles as the captured opcode: clear means a load is outstanding.
        if (mem_ack) begin
          state_d   = S_IDLE;
          mem_req_d = 1'b0;
          if (!mem_we_q) begin
            iw_en   = 1'b1;
            iw_addr = req_rd_q;
            iw_data = mem_rdata;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    dbg_rvalid_d = (dbg_rw == DBG_RD);
    dbg_rdata_d  = dbg_rvalid_d ? dbg_data : dbg_rdata_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      flags_q      <= '0;
      illegal_q    <= 1'b0;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      req_rd_q     <= '0;
      dbg_rdata_q  <= '0;
      dbg_rvalid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      flags_q      <= flags_d;
      illegal_q    <= illegal_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      req_rd_q     <= req_rd_d;
      dbg_rdata_q  <= dbg_rdata_d;
      dbg_rvalid_q <= dbg_rvalid_d;
    end
  end

  assign flags      = flags_q;
  assign illegal    = illegal_q;
  assign mem_req    = mem_req_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign dbg_rdata  = dbg_rdata_q;
  assign dbg_rvalid = dbg_rvalid_q;

endmodule

// File: doc/param_regfile.md
PARAM_REGFILE -- requirements
Module: param_regfile

Interface
REQ-001 SHALL have parameter DW, default 8, meaning register data width in bits.
REQ-002 SHALL have parameter NREG, default 4, meaning register count (power of 2, >=2); RW = clog2(NREG).
REQ-003 SHALL have parameter AW, default 4, meaning external memory address width.
REQ-004 SHALL have parameter IMMW, default 2, meaning MI immediate width (1..DW).
REQ-005 SHALL have ports:
- clk  in  1  rising-edge clock
- rst  in  1  reset, asynchronous, active-high
- in_valid  in  1  instruction valid
- in_ready  out  1  instruction accepted when in_valid & in_ready
- op  in  4  opcode
- rd  in  RW  destination register
- rs  in  RW  source register
- imm  in  IMMW  MI immediate
- addr  in  AW  memory address
- flags_in  in  2  {CY,Z} sampled on accept
- flags  out  2  latched {CY,Z}
- illegal  out  1  one-cycle pulse on unknown opcode
- mem_req  out  1  memory request
- mem_we  out  1  1 = store, 0 = load
- mem_addr  out  AW  request address
- mem_wdata  out  DW  store data
- mem_ack  in  1  request completion
- mem_rdata  in  DW  load data, valid with mem_ack
- dbg_rw  in  2  10 = read, 01 = write, else idle
- dbg_reg  in  RW  debug register index
- dbg_wdata  in  DW  debug write data
- dbg_rdata  out  DW  debug read data
- dbg_rvalid  out  1  pulse with dbg_rdata

Function
REQ-006 SHALL implement opcodes 0 LD (regs[rd] <= mem_rdata), 1 ST (mem[addr] <= regs[rs]), 2 MI (regs[rd] <= sign-extend(imm) to DW), 3 MR (regs[rd] <= regs[rs]).
REQ-007 SHALL implement FSM states IDLE and MEM.
- IDLE: in_ready = 1.
- MEM: in_ready = 0.
REQ-008 SHALL complete MI and MR in the accept cycle; the register updates at the edge ending that cycle and has no stall.
REQ-009 SHALL, on LD/ST accept, go IDLE->MEM and capture addr, rd, op and regs[rs] into request registers.
- mem_req rises the next cycle.
- mem_req holds stable until the cycle mem_ack = 1.
REQ-010 SHALL, on mem_ack in MEM, drop mem_req, return to IDLE and, for LD, write mem_rdata into regs[rd] at that edge.
- An LD/ST takes a minimum of 2 cycles (accept + 1 cycle ack).
REQ-011 SHALL ignore mem_ack while in IDLE.
REQ-012 SHALL latch flags <= flags_in on every accepted instruction only.
REQ-013 SHALL treat opcodes 4..15 as accepted no-ops: no register or flag-state side effects other than REQ-012, and illegal pulses for 1 cycle.
REQ-014 SHALL service the debug port every cycle independent of FSM state.
- Read: dbg_rdata = regs[dbg_reg] value before that edge's write, with dbg_rvalid = 1 one cycle later.
- Write: regs[dbg_reg] <= dbg_wdata.
REQ-015 SHALL, when an instruction write and a debug write target the same register in the same cycle, let the instruction write win; different targets both complete.
REQ-016 SHALL hold dbg_rdata at its last value when no read is issued.

Reset
REQ-017 SHALL, on rst, immediately clear:
- all regs, flags, illegal, mem_req, mem_we, mem_addr, mem_wdata, dbg_rdata and dbg_rvalid to 0;
- FSM to IDLE, so in_ready = 1 after rst deasserts.
REQ-018 SHALL abandon any in-flight LD/ST on reset mid-MEM, with no register write, and SHALL ignore any later mem_ack.

Structure
REQ-019 SHALL place opcode constants, the FSM state type and flag bit indices (CY = 1, Z = 0) in shared package param_regfile_pkg.
REQ-020 SHALL implement storage in sub-module regfile_array.
- 1 instruction write port, 1 debug write port with REQ-015 priority.
- 2 asynchronous read ports: rs and dbg_reg.

Verification
REQ-021 SHALL cover: MI rd=2, imm=2'b10 -> regs[2] = 8'hFE; MI rd=1, imm=2'b01 -> regs[1] = 8'h01; then MR rd=3, rs=2 -> debug read of reg 3 returns 8'hFE.
REQ-022 SHALL cover: regs[0] = 8'h5A, ST rs=0, addr=4'h7, mem_ack delayed 3 cycles -> mem_req high 3 cycles with mem_we=1, mem_addr=7, mem_wdata=8'h5A; in_ready low throughout.
REQ-023 SHALL cover: LD rd=1, addr=4'h3, mem_rdata = 8'hC3 with ack -> regs[1] = 8'hC3 one cycle after ack; in_valid held during MEM is not accepted until IDLE.
REQ-024 SHALL cover: same-cycle MI rd=0, imm=01 and debug write reg 0 = 8'hAA -> regs[0] = 8'h01; debug read in that cycle returns the old value.
REQ-025 SHALL cover: reset asserted during MEM of an LD, then a stale mem_ack -> no register change, mem_req = 0, in_ready = 1.
REQ-026 SHALL cover: op = 4'hF with flags_in = 2'b11 -> illegal pulses 1 cycle, flags = 2'b11, registers unchanged.
